// File: rtl/addsub_pkg.sv
// Shared encodings for the multi-cycle add/subtract unit: op select values and FSM states.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUBB = 2'b01,
        OP_PASS = 2'b10,
        OP_DEC  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/multicycle_addsub_alu_if.sv
// Operand/result valid-ready bundle between the operand FIFO, the ALU and the result consumer.
interface multicycle_addsub_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       s;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, s, cin, out_ready,
        input  in_ready, out_valid, d, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, s, cin, out_ready,
        output in_ready, out_valid, d, cout, ovf, zero
    );
endinterface

// File: rtl/cla_slice.sv
// One SLICE-bit carry-lookahead adder slice; every carry is a flat generate/propagate product.
module cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);
    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_c;
    logic             w_acc;
    logic             w_pp;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded rather than rippled
    always_comb begin
        w_c    = '0;
        w_acc  = 1'b0;
        w_pp   = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            w_acc = w_g[i];
            w_pp  = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc = w_acc | (w_pp & w_g[j]);
                w_pp  = w_pp & w_p[j];
            end
            w_c[i+1] = w_acc | (w_pp & cin);
        end
    end

    assign sum  = w_p ^ w_c[SLICE-1:0];
    assign cout = w_c[SLICE];

endmodule

// File: rtl/multicycle_addsub_alu.sv
// D = A + Y + CIN computed one CLA slice per clock, LSB first, with valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for an operand beat, in_ready=1
//   BUSY  | adding slice r_idx, carry held in r_carry
//   DONE  | result valid; in_ready follows out_ready for back-to-back accepts
module multicycle_addsub_alu
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    multicycle_addsub_alu_if.slave alu_bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] w_d_nxt;
    logic [WIDTH-1:0] w_y_sel;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [IDXW-1:0]  r_idx;
    logic [SLICE-1:0] w_slice_a;
    logic [SLICE-1:0] w_slice_y;
    logic [SLICE-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;

    always_comb begin
        w_y_sel = alu_bus.b;
        case (op_e'(alu_bus.s))
            OP_ADD:  w_y_sel = alu_bus.b;
            OP_SUBB: w_y_sel = ~alu_bus.b;
            OP_PASS: w_y_sel = '0;
            OP_DEC:  w_y_sel = '1;
            default: w_y_sel = alu_bus.b;
        endcase
    end

    assign w_slice_a = r_a[int'(r_idx)*SLICE +: SLICE];
    assign w_slice_y = r_y[int'(r_idx)*SLICE +: SLICE];

    cla_slice #(.SLICE(SLICE)) u_cla (
        .a    (w_slice_a),
        .b    (w_slice_y),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_comb begin
        w_d_nxt = r_d;
        w_d_nxt[int'(r_idx)*SLICE +: SLICE] = w_slice_sum;
    end

    assign w_last   = (r_state == BUSY) && (r_idx == IDXW'(NSLICE - 1));
    assign w_accept = alu_bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (alu_bus.in_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                w_in_ready = alu_bus.out_ready;
                if (alu_bus.out_ready) w_state_nxt = alu_bus.in_valid ? BUSY : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_y     <= '0;
            r_d     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= alu_bus.a;
            r_y     <= w_y_sel;
            r_carry <= alu_bus.cin;
            r_idx   <= '0;
        end else if (r_state == BUSY) begin
            r_d     <= w_d_nxt;
            r_carry <= w_slice_cout;
            r_idx   <= r_idx + 1'b1;
            // flags are frozen here so they stay stable for the whole DONE hold
            if (w_last) begin
                r_cout <= w_slice_cout;
                r_ovf  <= (r_a[WIDTH-1] == r_y[WIDTH-1]) && (w_d_nxt[WIDTH-1] != r_a[WIDTH-1]);
                r_zero <= (w_d_nxt == '0);
            end
        end
    end

    assign alu_bus.in_ready  = w_in_ready;
    assign alu_bus.out_valid = (r_state == DONE);
    assign alu_bus.d         = r_d;
    assign alu_bus.cout      = r_cout;
    assign alu_bus.ovf       = r_ovf;
    assign alu_bus.zero      = r_zero;

endmodule

// File: tb/tb_multicycle_addsub_alu.sv
// Self-checking bench for multicycle_addsub_alu: directed corner ops plus a randomized scoreboard sweep.
module tb_multicycle_addsub_alu;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic [15:0] d;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multicycle_addsub_alu_if #(.WIDTH(WIDTH)) alu_bus ();

    multicycle_addsub_alu #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .alu_bus (alu_bus.slave)
    );

    function automatic res_t ref_model(logic [15:0] a, logic [15:0] b, logic [1:0] s, logic cin);
        logic [15:0] y;
        logic [16:0] full;
        res_t        r;
        case (s)
            2'b00:   y = b;
            2'b01:   y = ~b;
            2'b10:   y = 16'h0000;
            default: y = 16'hFFFF;
        endcase
        full   = {1'b0, a} + {1'b0, y} + {16'b0, cin};
        r.d    = full[15:0];
        r.cout = full[16];
        r.ovf  = (a[15] == y[15]) && (r.d[15] != a[15]);
        r.zero = (r.d == 16'h0000);
        return r;
    endfunction

    function automatic string fmt(res_t r);
        return $sformatf("d=%h cout=%b ovf=%b zero=%b", r.d, r.cout, r.ovf, r.zero);
    endfunction

    function automatic res_t observed();
        res_t r;
        r.d    = alu_bus.d;
        r.cout = alu_bus.cout;
        r.ovf  = alu_bus.ovf;
        r.zero = alu_bus.zero;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic [1:0] op_s,
                          input logic op_cin, output res_t r, output int lat);
        int k;
        alu_bus.a         = op_a;
        alu_bus.b         = op_b;
        alu_bus.s         = op_s;
        alu_bus.cin       = op_cin;
        alu_bus.in_valid  = 1'b1;
        alu_bus.out_ready = 1'b1;
        k = 0;
        while (!alu_bus.in_ready && k < 50) begin
            step();
            k++;
        end
        step();
        alu_bus.in_valid = 1'b0;
        lat = 0;
        while (!alu_bus.out_valid && lat < 50) begin
            step();
            lat++;
        end
        r = observed();
        step();
    endtask

    task automatic test_reset();
        res_t r;
        int   lat;
        rst_n             = 1'b0;
        alu_bus.in_valid  = 1'b0;
        alu_bus.out_ready = 1'b1;
        alu_bus.a         = '0;
        alu_bus.b         = '0;
        alu_bus.s         = 2'b00;
        alu_bus.cin       = 1'b0;
        #3;
        checks++;
        if (alu_bus.in_ready !== 1'b1 || alu_bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, expected 1/0", alu_bus.in_ready, alu_bus.out_valid);
        end
        checks++;
        if (observed() !== res_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs: got %s, expected all zero", fmt(observed()));
        end
        step();
        step();
        rst_n = 1'b1;
        step();

        alu_bus.a        = 16'h1234;
        alu_bus.b        = 16'h1111;
        alu_bus.in_valid = 1'b1;
        step();
        alu_bus.in_valid = 1'b0;
        step();
        step();
        checks++;
        if (alu_bus.in_ready !== 1'b0 || alu_bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_before_reset: in_ready=%b out_valid=%b, expected 0/0", alu_bus.in_ready, alu_bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (alu_bus.out_valid !== 1'b0 || alu_bus.d !== 16'h0000 || alu_bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_busy: out_valid=%b d=%h in_ready=%b, expected 0/0000/1",
                     alu_bus.out_valid, alu_bus.d, alu_bus.in_ready);
        end
        #2 rst_n = 1'b1;
        step();
        run_op(16'h0001, 16'h0001, 2'b00, 1'b0, r, lat);
        checks++;
        if (r.d !== 16'h0002 || lat != 4) begin
            errors++;
            $display("FAIL after_reset_op: d=%h lat=%0d, expected d=0002 lat=4", r.d, lat);
        end
    endtask

    task automatic test_arith();
        logic [15:0] ta [8];
        logic [15:0] tb [8];
        logic [1:0]  ts [8];
        logic        tc [8];
        res_t        te [8];
        res_t        r;
        int          lat;
        ta[0] = 16'hFFFF; tb[0] = 16'h0001; ts[0] = 2'b00; tc[0] = 1'b0; te[0] = {16'h0000, 1'b1, 1'b0, 1'b1};
        ta[1] = 16'h7FFF; tb[1] = 16'h0001; ts[1] = 2'b00; tc[1] = 1'b0; te[1] = {16'h8000, 1'b0, 1'b1, 1'b0};
        ta[2] = 16'h8000; tb[2] = 16'h0001; ts[2] = 2'b01; tc[2] = 1'b1; te[2] = {16'h7FFF, 1'b1, 1'b1, 1'b0};
        ta[3] = 16'h1234; tb[3] = 16'h00FF; ts[3] = 2'b10; tc[3] = 1'b1; te[3] = {16'h1235, 1'b0, 1'b0, 1'b0};
        ta[4] = 16'h1234; tb[4] = 16'h00FF; ts[4] = 2'b11; tc[4] = 1'b0; te[4] = {16'h1233, 1'b1, 1'b0, 1'b0};
        ta[5] = 16'h1234; tb[5] = 16'h00FF; ts[5] = 2'b01; tc[5] = 1'b0; te[5] = {16'h1134, 1'b1, 1'b0, 1'b0};
        ta[6] = 16'h0005; tb[6] = 16'h0007; ts[6] = 2'b01; tc[6] = 1'b1; te[6] = {16'hFFFE, 1'b0, 1'b0, 1'b0};
        ta[7] = 16'h0FFF; tb[7] = 16'h0001; ts[7] = 2'b00; tc[7] = 1'b1; te[7] = {16'h1001, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], ts[i], tc[i], r, lat);
            checks++;
            if (r !== te[i]) begin
                errors++;
                $display("FAIL arith_%0d: got %s, expected %s", i, fmt(r), fmt(te[i]));
            end
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL latency_%0d: got %0d clks, expected 4", i, lat);
            end
        end
    endtask

    task automatic test_hold();
        res_t exp_r;
        exp_r = ref_model(16'hA5C3, 16'h3C5A, 2'b01, 1'b1);
        alu_bus.a         = 16'hA5C3;
        alu_bus.b         = 16'h3C5A;
        alu_bus.s         = 2'b01;
        alu_bus.cin       = 1'b1;
        alu_bus.out_ready = 1'b0;
        alu_bus.in_valid  = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            alu_bus.a        = 16'($urandom);
            alu_bus.b        = 16'($urandom);
            alu_bus.s        = 2'($urandom);
            alu_bus.cin      = 1'($urandom);
            alu_bus.in_valid = 1'($urandom);
            alu_bus.out_ready = 1'($urandom);
            #1;
            checks++;
            if (alu_bus.in_ready !== 1'b0 || alu_bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL busy_hs_%0d: in_ready=%b out_valid=%b, expected 0/0", i, alu_bus.in_ready, alu_bus.out_valid);
            end
            step();
        end
        alu_bus.out_ready = 1'b0;
        alu_bus.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            alu_bus.a = 16'($urandom);
            #1;
            checks++;
            if (alu_bus.out_valid !== 1'b1 || alu_bus.in_ready !== 1'b0 || observed() !== exp_r) begin
                errors++;
                $display("FAIL hold_%0d: out_valid=%b in_ready=%b %s, expected 1/0 %s",
                         i, alu_bus.out_valid, alu_bus.in_ready, fmt(observed()), fmt(exp_r));
            end
            step();
        end
        alu_bus.in_valid  = 1'b0;
        alu_bus.out_ready = 1'b1;
        step();
        checks++;
        if (alu_bus.out_valid !== 1'b0 || alu_bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b, expected 0/1", alu_bus.out_valid, alu_bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ba [3];
        logic [15:0] bb [3];
        logic [1:0]  bs [3];
        logic        bc [3];
        res_t        exp_q [$];
        res_t        got;
        res_t        want;
        logic        acc;
        logic        cpl;
        int          beat;
        int          cyc;
        int          last_done;
        int          ndone;
        ba[0] = 16'h0001; bb[0] = 16'h0002; bs[0] = 2'b00; bc[0] = 1'b0;
        ba[1] = 16'hFFFF; bb[1] = 16'h0001; bs[1] = 2'b01; bc[1] = 1'b1;
        ba[2] = 16'h8000; bb[2] = 16'h8000; bs[2] = 2'b00; bc[2] = 1'b0;
        beat = 0; cyc = 0; last_done = 0; ndone = 0;
        alu_bus.a = ba[0]; alu_bus.b = bb[0]; alu_bus.s = bs[0]; alu_bus.cin = bc[0];
        alu_bus.in_valid  = 1'b1;
        alu_bus.out_ready = 1'b1;
        #1;
        while (ndone < 3 && cyc < 100) begin
            acc = alu_bus.in_valid && alu_bus.in_ready;
            cpl = alu_bus.out_valid && alu_bus.out_ready;
            got = observed();
            if (acc) exp_q.push_back(ref_model(alu_bus.a, alu_bus.b, alu_bus.s, alu_bus.cin));
            step();
            cyc++;
            if (cpl) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : res_t'('x);
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got %s, expected %s", ndone, fmt(got), fmt(want));
                end
                if (ndone > 0) begin
                    checks++;
                    if (cyc - last_done != 5) begin
                        errors++;
                        $display("FAIL b2b_interval_%0d: got %0d clks, expected 5", ndone, cyc - last_done);
                    end
                end
                last_done = cyc;
                ndone++;
            end
            if (acc) begin
                beat++;
                if (beat < 3) begin
                    alu_bus.a = ba[beat]; alu_bus.b = bb[beat]; alu_bus.s = bs[beat]; alu_bus.cin = bc[beat];
                end else begin
                    alu_bus.in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (ndone != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, expected 3", ndone);
        end
        step();
    endtask

    task automatic test_random();
        res_t exp_q [$];
        res_t got;
        res_t want;
        logic acc;
        logic cpl;
        int   naccepted;
        int   ndone;
        int   cyc;
        int   bad;
        logic [15:0] corners [4];
        corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h8000; corners[3] = 16'h7FFF;
        naccepted = 0; ndone = 0; cyc = 0; bad = 0;
        alu_bus.in_valid = 1'b0;
        while (ndone < 2000 && cyc < 40000) begin
            acc = alu_bus.in_valid && alu_bus.in_ready;
            cpl = alu_bus.out_valid && alu_bus.out_ready;
            got = observed();
            if (acc) begin
                exp_q.push_back(ref_model(alu_bus.a, alu_bus.b, alu_bus.s, alu_bus.cin));
                naccepted++;
            end
            step();
            cyc++;
            if (cpl) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : res_t'('x);
                checks++;
                if (got !== want) begin
                    errors++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL random_op_%0d: got %s, expected %s", ndone, fmt(got), fmt(want));
                end
                ndone++;
            end
            alu_bus.a   = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            alu_bus.b   = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            alu_bus.s   = 2'($urandom_range(0, 3));
            alu_bus.cin = 1'($urandom);
            alu_bus.in_valid  = (naccepted < 2000) && ($urandom_range(0, 3) != 0);
            alu_bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
        end
        checks++;
        if (ndone != 2000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_count: got %0d results with %0d pending, expected 2000 with 0", ndone, exp_q.size());
        end
        alu_bus.in_valid  = 1'b0;
        alu_bus.out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_hold();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
